// File: rtl/extend_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 20-to-32 immediate extender.
// One-deep registered output with ready/valid handshake and a modulo-256 transfer counter.
module extend_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [1:0]  a_type,
    input  logic [19:0] a_imm,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [1:0]  b_type,
    input  logic [19:0] b_imm,
    output logic        b_ready,
    output logic        out_valid,
    output logic        out_id,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic [7:0]  xfer_cnt
);

    typedef enum logic {StEmpty, StFull} state_e;

    localparam logic OwnerA = 1'b0;
    localparam logic OwnerB = 1'b1;

    state_e      state_q, state_d;
    logic        id_q, id_d;
    logic [31:0] data_q, data_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        grant_a, grant_b;
    logic        can_load;
    logic        a_accept, b_accept, accept;
    logic        xfer;
    logic [1:0]  sel_type;
    logic [19:0] sel_imm;
    logic [31:0] ext_data;

    function automatic logic [31:0] extend(input logic [1:0] kind, input logic [19:0] imm);
        logic [31:0] r;
        unique case (kind)
            2'b00:   r = {{20{imm[11]}}, imm[11:0]};
            2'b01:   r = {{19{imm[11]}}, imm[11:0], 1'b0};
            2'b10:   r = {imm, 12'h000};
            default: r = {{11{imm[19]}}, imm, 1'b0};
        endcase
        return r;
    endfunction

    // Round-robin: on a tie the requester that was not served last wins.
    always_comb begin
        grant_a  = a_valid && (!b_valid || (last_q == OwnerB));
        grant_b  = b_valid && (!a_valid || (last_q == OwnerA));
        can_load = (state_q == StEmpty) || out_ready;
        a_ready  = !rst && grant_a && can_load;
        b_ready  = !rst && grant_b && can_load;
        a_accept = a_valid && a_ready;
        b_accept = b_valid && b_ready;
        accept   = a_accept || b_accept;
        xfer     = (state_q == StFull) && out_ready;
    end

    // Shared extension datapath, steered by the winning requester.
    always_comb begin
        sel_type = b_accept ? b_type : a_type;
        sel_imm  = b_accept ? b_imm  : a_imm;
        ext_data = extend(sel_type, sel_imm);
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q + {7'b0, xfer};
        if (accept) begin
            state_d = StFull;
            id_d    = b_accept;
            data_d  = ext_data;
            last_d  = b_accept;
        end else if (xfer) begin
            state_d = StEmpty;
            data_d  = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            id_q    <= OwnerA;
            data_q  <= 32'h0;
            last_q  <= OwnerB;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        out_valid = (state_q == StFull);
        out_id    = id_q;
        out_data  = data_q;
        xfer_cnt  = cnt_q;
    end

endmodule
